alu_result_serializer: RTL and testbench

//  Downstream stage of the n_alu-wide ALU bank. Captures each ALU result (out, carry_out,
//  a_greater/a_equal/a_less, select) into a DEPTH-entry FIFO. Streams every result out as
//  8 beats of WIDTH*N_ALU bits over a valid/ready link, decoupling ALU issue rate from the consumer.

---
 rtl/alu_stream_pkg.sv | 29 ++
 rtl/alu_result_fifo.sv | 64 ++++++
 rtl/alu_result_serializer.sv | 146 ++++++++++++++
 tb/tb_alu_result_serializer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stream_pkg.sv
// alu_stream_pkg: shared types and constants for the ALU result serializer.
//   BEATS        beats per result packet
//   alu_result_t result record for the default bank (WIDTH=4, N_ALU=4)
//   ser_state_t  serializer FSM states
//   is_onehot3   flag-vector sanity check
package alu_stream_pkg;

    localparam int unsigned BEATS     = 8;
    localparam int unsigned BEAT_W    = 3;
    localparam int unsigned DEF_CHUNK = 16;

    typedef struct packed {
        logic [2:0]                   select;
        logic [2:0]                   flags;
        logic                         carry;
        logic [BEATS*DEF_CHUNK-1:0]   data;
    } alu_result_t;

    typedef enum logic {
        IDLE,
        STREAM
    } ser_state_t;

    // {a_greater, a_equal, a_less} must have exactly one bit set.
    function automatic logic is_onehot3(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: DEPTH-entry synchronous FIFO holding whole ALU result records.
// Ports:
//   clk, arst        clock, synchronous active-high reset
//   push, wdata      write strobe (caller guarantees !full) and record
//   pop              read strobe (caller guarantees !empty)
//   full, empty      status from the registered count
//   count            occupancy 0..DEPTH
//   head             record at the read pointer
module alu_result_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DW-1:0]            head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage is not reset; only the head slot is ever observed and only while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: queues ALU bank results and streams each one as 8 beats of
// WIDTH*N_ALU bits over a valid/ready link.
// Ports:
//   clk, arst                 clock, synchronous active-high reset
//   in_valid / in_ready       result handshake (in_ready = FIFO not full)
//   in_out, in_carry,
//   in_flags, in_select       result payload
//   out_valid / out_ready     beat handshake
//   out_data, out_beat,
//   out_last, out_side        current beat slice, index, last marker, packet sideband
//   pkt_cnt                   packets fully sent (wraps)
//   flag_err                  sticky: a pushed result had non-one-hot flags
module alu_result_serializer
    import alu_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N_ALU = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BEATS*WIDTH*N_ALU-1:0]     in_out,
    input  logic                             in_carry,
    input  logic [2:0]                       in_flags,
    input  logic [2:0]                       in_select,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH*N_ALU-1:0]           out_data,
    output logic [2:0]                       out_beat,
    output logic                             out_last,
    output logic [6:0]                       out_side,
    output logic [7:0]                       pkt_cnt,
    output logic                             flag_err
);

    localparam int unsigned CHUNK = WIDTH * N_ALU;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    // Same layout as alu_result_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [2:0]             select;
        logic [2:0]             flags;
        logic                   carry;
        logic [BEATS*CHUNK-1:0] data;
    } entry_t;

    entry_t        wr_entry, head;
    logic          full, empty;
    logic [CW-1:0] count;
    logic          push, pop, fire;

    ser_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [7:0]        pkt_cnt_q, pkt_cnt_d;
    logic              flag_err_q, flag_err_d;

    assign wr_entry = '{select: in_select, flags: in_flags, carry: in_carry, data: in_out};

    alu_result_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // in_ready uses only the registered count: a full FIFO refuses even while popping.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign fire     = (state_q == STREAM) && out_ready;
    assign pop      = fire && (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pkt_cnt_d  = pkt_cnt_q;
        flag_err_d = flag_err_q;

        if (push && !is_onehot3(in_flags)) begin
            flag_err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // Looking at the push directly gives beat 0 the cycle after the push.
                if (!empty || push) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (fire) begin
                    beat_d = beat_q + 1'b1;  // 7 wraps to 0
                end
                if (pop) begin
                    pkt_cnt_d = pkt_cnt_q + 8'd1;
                    // Something remains after this pop if another entry was queued or one
                    // arrives this very cycle.
                    if (!((count > CW'(1)) || push)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            pkt_cnt_q  <= '0;
            flag_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            pkt_cnt_q  <= pkt_cnt_d;
            flag_err_q <= flag_err_d;
        end
    end

    // Outputs come from the head entry only, and are zeroed while idle.
    always_comb begin
        out_valid = (state_q == STREAM);
        out_beat  = beat_q;
        out_last  = out_valid && (beat_q == BEAT_W'(BEATS - 1));
        out_data  = '0;
        out_side  = '0;
        if (out_valid) begin
            out_data = head.data[int'(beat_q)*CHUNK +: CHUNK];
            out_side = {head.select, head.flags, head.carry};
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign flag_err = flag_err_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer (WIDTH=4, N_ALU=4, DEPTH=4, CHUNK=16).
module tb_alu_result_serializer;

    localparam int CHUNK = 16;

    logic               clk = 1'b0;
    logic               arst;
    logic               in_valid;
    logic               in_ready;
    logic [8*CHUNK-1:0] in_out;
    logic               in_carry;
    logic [2:0]         in_flags;
    logic [2:0]         in_select;
    logic               out_valid;
    logic               out_ready;
    logic [CHUNK-1:0]   out_data;
    logic [2:0]         out_beat;
    logic               out_last;
    logic [6:0]         out_side;
    logic [7:0]         pkt_cnt;
    logic               flag_err;

    int n_vec = 0;
    int n_err = 0;

    logic [8*CHUNK-1:0] d1 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;

    alu_result_serializer #(
        .WIDTH (4),
        .N_ALU (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_out    (in_out),
        .in_carry  (in_carry),
        .in_flags  (in_flags),
        .in_select (in_select),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .out_side  (out_side),
        .pkt_cnt   (pkt_cnt),
        .flag_err  (flag_err)
    );

    always #5 clk = ~clk;

    // Result k: beat b carries 16'h1000*(k+1) + b.
    function automatic logic [8*CHUNK-1:0] payload(input int k);
        logic [8*CHUNK-1:0] v;
        for (int b = 0; b < 8; b++) begin
            v[b*CHUNK +: CHUNK] = 16'(16'h1000 * (k + 1) + b);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_flags = 3'b010; in_select = 3'b000; in_carry = 1'b0; in_out = '0;
        tick();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_out = d1;
        in_flags = 3'b010; in_select = 3'b111; in_carry = 1'b1;
        tick();
        arst = 1'b0; in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_data !== 16'h0 || out_beat !== 3'd0 || out_last !== 1'b0 || out_side !== 7'h0) begin
            n_err++; $display("FAIL reset outputs: got data=%h beat=%0d last=%b side=%b want all 0",
                              out_data, out_beat, out_last, out_side); end
        n_vec++; if (pkt_cnt !== 8'd0 || flag_err !== 1'b0) begin
            n_err++; $display("FAIL reset counters: got pkt_cnt=%0d flag_err=%b want 0/0", pkt_cnt, flag_err); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset push_overridden: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_single_packet();
        do_reset();
        out_ready = 1'b1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single in_ready: got %b want 1", in_ready); end
        in_valid = 1'b1; in_out = d1; in_flags = 3'b010; in_select = 3'b101; in_carry = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_beat !== 3'(b) || out_data !== {8'(2*b+1), 8'(2*b)} ||
                out_last !== (b == 7) || out_side !== 7'b101_010_1) begin
                n_err++;
                $display("FAIL single beat%0d: got v=%b beat=%0d data=%h last=%b side=%b want 1/%0d/%h/%b/1010101",
                         b, out_valid, out_beat, out_data, out_last, out_side, b, {8'(2*b+1), 8'(2*b)}, b == 7);
            end
            tick();
        end
        n_vec++; if (out_valid !== 1'b0 || pkt_cnt !== 8'd1) begin
            n_err++; $display("FAIL single done: got out_valid=%b pkt_cnt=%0d want 0/1", out_valid, pkt_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_out = d1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_beat !== 3'd3 || out_data !== 16'h0706 || out_last !== 1'b0) begin
                n_err++;
                $display("FAIL stall hold%0d: got v=%b beat=%0d data=%h last=%b want 1/3/0706/0",
                         i, out_valid, out_beat, out_data, out_last);
            end
        end
        out_ready = 1'b1;
        for (int b = 3; b < 8; b++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_beat !== 3'(b) || out_data !== {8'(2*b+1), 8'(2*b)}) begin
                n_err++;
                $display("FAIL stall resume beat%0d: got v=%b beat=%0d data=%h want 1/%0d/%h",
                         b, out_valid, out_beat, out_data, b, {8'(2*b+1), 8'(2*b)});
            end
            tick();
        end
        n_vec++; if (out_valid !== 1'b0 || pkt_cnt !== 8'd1) begin
            n_err++; $display("FAIL stall done: got out_valid=%b pkt_cnt=%0d want 0/1", out_valid, pkt_cnt); end
    endtask

    task automatic test_fill();
        int beats;
        int pk;
        int bexp;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (in_ready !== (k < 4)) begin
                n_err++; $display("FAIL fill in_ready push%0d: got %b want %b", k, in_ready, k < 4);
            end
            in_valid = 1'b1; in_out = payload(k);
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill in_ready after5: got %b want 0", in_ready); end
        out_ready = 1'b1;
        beats = 0; pk = 0; bexp = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                n_vec++;
                if (out_beat !== 3'(bexp) || out_data !== 16'(16'h1000 * (pk + 1) + bexp)) begin
                    n_err++;
                    $display("FAIL fill stream pkt%0d: got beat=%0d data=%h want %0d/%h",
                             pk, out_beat, out_data, bexp, 16'(16'h1000 * (pk + 1) + bexp));
                end
                beats++;
                if (bexp == 7) begin bexp = 0; pk++; end else bexp++;
            end
            tick();
        end
        n_vec++; if (beats != 32 || pkt_cnt !== 8'd4 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL fill totals: got beats=%0d pkt_cnt=%0d out_valid=%b want 32/4/0",
                              beats, pkt_cnt, out_valid); end
    endtask

    task automatic test_full_pop();
        int cnt;
        logic [CHUNK-1:0] last_d;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_out = payload(k);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (7) tick();
        n_vec++; if (out_beat !== 3'd7 || out_last !== 1'b1) begin
            n_err++; $display("FAIL fullpop at_last: got beat=%0d last=%b want 7/1", out_beat, out_last); end
        in_valid = 1'b1; in_out = payload(4);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fullpop refused: got in_ready=%b want 0", in_ready); end
        tick();
        n_vec++; if (in_ready !== 1'b1 || out_beat !== 3'd0 || pkt_cnt !== 8'd1) begin
            n_err++; $display("FAIL fullpop after_pop: got in_ready=%b beat=%0d pkt_cnt=%0d want 1/0/1",
                              in_ready, out_beat, pkt_cnt); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0 || out_beat !== 3'd1) begin
            n_err++; $display("FAIL fullpop accepted: got in_ready=%b beat=%0d want 0/1", in_ready, out_beat); end
        cnt = 0; last_d = '0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                cnt++;
                if (out_last) last_d = out_data;
            end
            tick();
        end
        n_vec++; if (cnt != 31 || pkt_cnt !== 8'd5 || last_d !== 16'h5007) begin
            n_err++; $display("FAIL fullpop drain: got beats=%0d pkt_cnt=%0d last=%h want 31/5/5007",
                              cnt, pkt_cnt, last_d); end
    endtask

    task automatic test_flag_err();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_out = payload(0); in_flags = 3'b110; in_select = 3'b011; in_carry = 1'b0;
        tick();
        in_valid = 1'b0;
        n_vec++; if (flag_err !== 1'b1 || out_valid !== 1'b1 || out_side !== 7'b011_110_0) begin
            n_err++; $display("FAIL flagerr set: got flag_err=%b v=%b side=%b want 1/1/0111100",
                              flag_err, out_valid, out_side); end
        repeat (7) tick();
        n_vec++; if (out_last !== 1'b1 || out_side !== 7'b011_110_0 || out_data !== 16'h1007) begin
            n_err++; $display("FAIL flagerr last: got last=%b side=%b data=%h want 1/0111100/1007",
                              out_last, out_side, out_data); end
        tick();
        n_vec++; if (flag_err !== 1'b1 || pkt_cnt !== 8'd1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL flagerr streamed: got flag_err=%b pkt_cnt=%0d v=%b want 1/1/0",
                              flag_err, pkt_cnt, out_valid); end
        in_valid = 1'b1; in_flags = 3'b001;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        n_vec++; if (flag_err !== 1'b1 || pkt_cnt !== 8'd2) begin
            n_err++; $display("FAIL flagerr sticky: got flag_err=%b pkt_cnt=%0d want 1/2", flag_err, pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_out = payload(k);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        n_vec++; if (out_beat !== 3'd4 || pkt_cnt !== 8'd1 || out_data !== 16'h2004) begin
            n_err++; $display("FAIL rstmid before: got beat=%0d pkt_cnt=%0d data=%h want 4/1/2004",
                              out_beat, pkt_cnt, out_data); end
        arst = 1'b1;
        tick();
        arst = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || pkt_cnt !== 8'd0 || out_beat !== 3'd0 ||
                     out_side !== 7'h0) begin
            n_err++; $display("FAIL rstmid after: got v=%b in_ready=%b pkt_cnt=%0d beat=%0d side=%b want 0/1/0/0/0",
                              out_valid, in_ready, pkt_cnt, out_beat, out_side); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid flushed: got v=%b want 0", out_valid); end
        in_valid = 1'b1; in_out = d1; in_flags = 3'b010;
        tick();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || out_beat !== 3'd0 || out_data !== 16'h0100 || pkt_cnt !== 8'd0) begin
            n_err++; $display("FAIL rstmid fresh: got v=%b beat=%0d data=%h pkt_cnt=%0d want 1/0/0100/0",
                              out_valid, out_beat, out_data, pkt_cnt); end
        repeat (8) tick();
        n_vec++; if (out_valid !== 1'b0 || pkt_cnt !== 8'd1) begin
            n_err++; $display("FAIL rstmid fresh_done: got v=%b pkt_cnt=%0d want 0/1", out_valid, pkt_cnt); end
    endtask

    initial begin
        arst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_out = '0;
        in_carry = 1'b0; in_flags = 3'b010; in_select = 3'b000;
        #2;
        test_reset();
        test_single_packet();
        test_stall();
        test_fill();
        test_full_pop();
        test_flag_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
